flag_branch_unit: RTL and testbench
===================================

// Module: flag_branch_unit
// PURPOSE
// Consumer side of the ALU flag interface: captures N/V/Z from the EX-stage ALU into the
// architectural flag register, applies per-opcode flag-update enables, and resolves
// conditional branches in ID using bypassed or registered flags. Registered taken/redirect
// result; saturating branch and taken-branch counters for performance debug.
// PARAMETERS
// CNT_W     16   width of the saturating perf counters br_cnt / taken_cnt
// PORTS
// clk          in   1      clock, all state updates on rising edge
// rst          in   1      synchronous, active-high reset
// ex_valid     in   1      EX-stage instruction is valid
// ex_control   in   4      ALU control/opcode of EX instruction (0=ADD,1=SUB,2=XOR,4=SLL,5=SRA,6=ROR ...)
// ex_N         in   1      ALU N flag output
// ex_V         in   1      ALU V flag output
// ex_Z         in   1      ALU Z flag output
// stall        in   1      pipeline stall; freezes all state
// flush        in   1      squash the ID-stage branch this cycle
// br_valid     in   1      ID stage holds a branch instruction
// br_ccc       in   3      branch condition code
// br_target    in   16     branch target address
// flags        out  3      architectural flags {N,V,Z}
// br_done      out  1      one-cycle pulse: branch resolved last cycle
// br_taken     out  1      resolved branch taken (qualified by br_done)
// br_pc        out  16     registered target when br_taken
// br_cnt       out  CNT_W  resolved branches, saturating
// taken_cnt    out  CNT_W  taken branches, saturating
// BEHAVIOUR
// - Reset: flags=3'b000, br_done=0, br_taken=0, br_pc=0, br_cnt=0, taken_cnt=0. Reset wins over
//   stall/flush and aborts any in-flight resolution (br_done never pulses for it).
// - Flag enables (only when ex_valid & !stall): control 0,1 write N,V,Z; 2,4,5,6 write Z only
//   (N,V hold); all other codes write nothing. ALU zeros on non-updating flags are ignored.
// - Bypass: eff flag = new EX value if its enable is active this cycle, else flags register.
//   Per-flag: e.g. XOR in EX bypasses Z but N,V come from register.
// - Conditions (eff flags): 000 NE Z=0; 001 EQ Z=1; 010 GT Z=0&N=0; 011 LT N=1;
//   100 GE Z=1|(Z=0&N=0); 101 LE N=1|Z=1; 110 OVFL V=1; 111 UNCOND always taken.
// - Resolve when br_valid & !stall & !flush: next cycle br_done=1, br_taken=cond,
//   br_pc=br_target if taken else 0; br_cnt+=1, taken_cnt+=cond. Latency 1 cycle.
// - No resolution: br_done=0 next cycle; br_taken/br_pc hold prior values.
// - stall=1: flags, counters, outputs hold; br_done drops to 0 after one cycle (pulse, not held).
// - flush=1 with br_valid: branch dropped, counters untouched; EX flag update still occurs.
// - Counters saturate at 2^CNT_W-1; taken_cnt never exceeds br_cnt.
// - Back-to-back branches each resolve; br_done may stay high on consecutive cycles.
// TESTING
// - rst held 2 cycles then released -> flags=000, br_done=0, both counters 0.
// - EX SUB 5-5 (ex_Z=1,N=0,V=0) with ID br_ccc=001 same cycle -> next cycle br_done=1,
//   br_taken=1, br_pc=target, flags=001 (bypass proven, register idle before).
// - flags={N=1,V=1,Z=0}; EX XOR with ex_Z=1,ex_N=0,ex_V=0 -> flags=110 then 111? no: N,V hold,
//   Z set -> flags={1,1,1}; br_ccc=110 same cycle -> taken (V from register).
// - br_valid with stall=1 for 3 cycles then released -> exactly one br_done pulse, br_cnt+1.
// - br_valid with flush=1, ccc=111 -> no br_done, counters unchanged; EX ADD flags still latched.
// - CNT_W=4, 20 UNCOND branches -> br_cnt=taken_cnt=15 saturated; rst mid-burst -> both 0.

Source files
------------

// File: rtl/flag_branch_if.sv
// ALU-flag / branch-resolution bundle between the pipeline (master) and flag_branch_unit (slave).
interface flag_branch_if #(
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic [3:0]       ex_control;
  logic             ex_N;
  logic             ex_V;
  logic             ex_Z;
  logic             stall;
  logic             flush;
  logic             br_valid;
  logic [2:0]       br_ccc;
  logic [15:0]      br_target;
  logic [2:0]       flags;
  logic             br_done;
  logic             br_taken;
  logic [15:0]      br_pc;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output ex_valid, ex_control, ex_N, ex_V, ex_Z, stall, flush,
    output br_valid, br_ccc, br_target,
    input  flags, br_done, br_taken, br_pc, br_cnt, taken_cnt
  );

  modport slave (
    input  ex_valid, ex_control, ex_N, ex_V, ex_Z, stall, flush,
    input  br_valid, br_ccc, br_target,
    output flags, br_done, br_taken, br_pc, br_cnt, taken_cnt
  );
endinterface

// File: rtl/flag_branch_unit.sv
// Architectural N/V/Z flag register with per-opcode update enables, per-flag EX bypass,
// registered branch resolution in ID, and saturating branch / taken-branch counters.
module flag_branch_unit #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  flag_branch_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GE     = 3'b100;
  localparam logic [2:0] CC_LE     = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  logic [2:0]       flags_q;
  logic             br_done_q;
  logic             br_taken_q;
  logic [15:0]      br_pc_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;

  logic upd_nv;
  logic upd_z;
  logic eff_n;
  logic eff_v;
  logic eff_z;
  logic cond;
  logic resolve;

  // Arithmetic ops own all three flags; logic/shift ops only produce a meaningful Z.
  always_comb begin
    upd_nv = 1'b0;
    upd_z  = 1'b0;
    if (bus.ex_valid && !bus.stall) begin
      case (bus.ex_control)
        4'd0, 4'd1: begin
          upd_nv = 1'b1;
          upd_z  = 1'b1;
        end
        4'd2, 4'd4, 4'd5, 4'd6: upd_z = 1'b1;
        default: ;
      endcase
    end
  end

  assign eff_n = upd_nv ? bus.ex_N : flags_q[2];
  assign eff_v = upd_nv ? bus.ex_V : flags_q[1];
  assign eff_z = upd_z  ? bus.ex_Z : flags_q[0];

  always_comb begin
    cond = 1'b0;
    case (bus.br_ccc)
      CC_NE:     cond = !eff_z;
      CC_EQ:     cond = eff_z;
      CC_GT:     cond = !eff_z && !eff_n;
      CC_LT:     cond = eff_n;
      CC_GE:     cond = eff_z || (!eff_z && !eff_n);
      CC_LE:     cond = eff_n || eff_z;
      CC_OVFL:   cond = eff_v;
      CC_UNCOND: cond = 1'b1;
      default:   cond = 1'b0;
    endcase
  end

  assign resolve = bus.br_valid && !bus.stall && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q     <= 3'b000;
      br_done_q   <= 1'b0;
      br_taken_q  <= 1'b0;
      br_pc_q     <= 16'h0000;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (upd_nv) begin
        flags_q[2] <= bus.ex_N;
        flags_q[1] <= bus.ex_V;
      end
      if (upd_z) begin
        flags_q[0] <= bus.ex_Z;
      end
      br_done_q <= resolve;
      if (resolve) begin
        br_taken_q <= cond;
        br_pc_q    <= cond ? bus.br_target : 16'h0000;
        if (br_cnt_q != CNT_MAX) begin
          br_cnt_q <= br_cnt_q + CNT_ONE;
        end
        // taken_cnt only moves alongside br_cnt, so it can never overtake it.
        if (cond && (taken_cnt_q != CNT_MAX)) begin
          taken_cnt_q <= taken_cnt_q + CNT_ONE;
        end
      end
    end
  end

  assign bus.flags     = flags_q;
  assign bus.br_done   = br_done_q;
  assign bus.br_taken  = br_taken_q;
  assign bus.br_pc     = br_pc_q;
  assign bus.br_cnt    = br_cnt_q;
  assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: a 16-bit-counter instance and a 4-bit-counter
// instance driven with identical stimulus and checked against a bench-side model.
module tb_flag_branch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flag_branch_if #(.CNT_W(16)) bus16();
  flag_branch_if #(.CNT_W(4))  bus4();

  flag_branch_unit #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  flag_branch_unit #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

  typedef struct {
    logic        taken;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  logic [2:0]  m_flags;
  int          m16_br, m16_tk, m4_br, m4_tk;
  logic        m_taken;
  logic [15:0] m_pc;

  function automatic logic cond_of(input logic [2:0] ccc, input logic n, input logic v,
                                   input logic z);
    case (ccc)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || (!z && !n);
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of stimulus on both instances and advances the model.
  task automatic drive(input logic r, input logic ev, input logic [3:0] ctl,
                       input logic n, input logic v, input logic z,
                       input logic st, input logic fl, input logic bv,
                       input logic [2:0] ccc, input logic [15:0] tgt);
    logic en_nv, en_z, en, c;
    logic pn, pv, pz;
    rst = r;
    bus16.ex_valid = ev; bus16.ex_control = ctl; bus16.ex_N = n; bus16.ex_V = v;
    bus16.ex_Z = z; bus16.stall = st; bus16.flush = fl; bus16.br_valid = bv;
    bus16.br_ccc = ccc; bus16.br_target = tgt;
    bus4.ex_valid = ev; bus4.ex_control = ctl; bus4.ex_N = n; bus4.ex_V = v;
    bus4.ex_Z = z; bus4.stall = st; bus4.flush = fl; bus4.br_valid = bv;
    bus4.br_ccc = ccc; bus4.br_target = tgt;
    if (r) begin
      m_flags = 3'b000; m16_br = 0; m16_tk = 0; m4_br = 0; m4_tk = 0;
      m_taken = 1'b0; m_pc = 16'h0;
    end else begin
      en    = ev && !st;
      en_nv = en && (ctl == 4'd0 || ctl == 4'd1);
      en_z  = en && (ctl == 4'd0 || ctl == 4'd1 || ctl == 4'd2 || ctl == 4'd4 ||
                     ctl == 4'd5 || ctl == 4'd6);
      pn = en_nv ? n : m_flags[2];
      pv = en_nv ? v : m_flags[1];
      pz = en_z  ? z : m_flags[0];
      c  = cond_of(ccc, pn, pv, pz);
      if (bv && !st && !fl) begin
        sb.push_back('{taken: c, pc: (c ? tgt : 16'h0)});
        m_taken = c;
        m_pc    = c ? tgt : 16'h0;
        if (m16_br < 65535) m16_br++;
        if (c && m16_tk < 65535) m16_tk++;
        if (m4_br < 15) m4_br++;
        if (c && m4_tk < 15) m4_tk++;
      end
      m_flags = {pn, pv, pz};
    end
    cyc();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
  endtask

  // Scoreboard monitor: each br_done pulse pops one expected resolution.
  always @(negedge clk) begin
    if (bus16.br_done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: br_done=1 with no branch outstanding (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        if (bus16.br_taken !== e.taken || bus16.br_pc !== e.pc) begin
          errors++;
          $display("FAIL sb_result16: taken=%b pc=%h, expected taken=%b pc=%h (t=%0t)",
                   bus16.br_taken, bus16.br_pc, e.taken, e.pc, $time);
        end
        checks++;
        if (bus4.br_done !== 1'b1 || bus4.br_taken !== e.taken || bus4.br_pc !== e.pc) begin
          errors++;
          $display("FAIL sb_result4: done=%b taken=%b pc=%h, expected done=1 taken=%b pc=%h",
                   bus4.br_done, bus4.br_taken, bus4.br_pc, e.taken, e.pc);
        end
      end
    end
  end

  task automatic test_reset();
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    idle();
    checks++;
    if (bus16.flags !== 3'b000 || bus16.br_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: flags=%b br_done=%b, expected 000/0", bus16.flags, bus16.br_done);
    end
    checks++;
    if (bus16.br_cnt !== 16'd0 || bus16.taken_cnt !== 16'd0 || bus16.br_taken !== 1'b0 ||
        bus16.br_pc !== 16'h0) begin
      errors++;
      $display("FAIL reset_counters: br_cnt=%0d taken_cnt=%0d taken=%b pc=%h, expected zeros",
               bus16.br_cnt, bus16.taken_cnt, bus16.br_taken, bus16.br_pc);
    end
    checks++;
    if (bus4.br_cnt !== 4'd0 || bus4.taken_cnt !== 4'd0 || bus4.flags !== 3'b000) begin
      errors++;
      $display("FAIL reset_small: br_cnt=%0d taken_cnt=%0d flags=%b, expected zeros",
               bus4.br_cnt, bus4.taken_cnt, bus4.flags);
    end
  endtask

  task automatic test_bypass();
    // SUB 5-5 in EX, BEQ in ID on the same cycle; register Z is still 0.
    drive(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 16'h1234);
    checks++;
    if (bus16.br_done !== 1'b1 || bus16.br_taken !== 1'b1 || bus16.br_pc !== 16'h1234) begin
      errors++;
      $display("FAIL bypass_eq: done=%b taken=%b pc=%h, expected 1/1/1234",
               bus16.br_done, bus16.br_taken, bus16.br_pc);
    end
    checks++;
    if (bus16.flags !== 3'b001) begin
      errors++;
      $display("FAIL bypass_flags: flags=%b, expected 001", bus16.flags);
    end
    idle();
  endtask

  task automatic test_partial_update();
    drive(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    checks++;
    if (bus16.flags !== 3'b110) begin
      errors++;
      $display("FAIL add_flags: flags=%b, expected 110", bus16.flags);
    end
    // XOR writes Z only; OVFL must see V from the register.
    drive(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b110, 16'hBEEF);
    checks++;
    if (bus16.flags !== 3'b111 || bus16.br_taken !== 1'b1) begin
      errors++;
      $display("FAIL xor_partial: flags=%b taken=%b, expected 111/1", bus16.flags, bus16.br_taken);
    end
    // SRA clears Z via bypass; BEQ must not be taken.
    drive(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 16'h2222);
    checks++;
    if (bus16.flags !== 3'b110 || bus16.br_taken !== 1'b0 || bus16.br_pc !== 16'h0) begin
      errors++;
      $display("FAIL sra_partial: flags=%b taken=%b pc=%h, expected 110/0/0000",
               bus16.flags, bus16.br_taken, bus16.br_pc);
    end
    // Opcode 3 updates nothing: its Z=1 must be neither bypassed nor latched.
    drive(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 16'h3333);
    checks++;
    if (bus16.flags !== 3'b110 || bus16.br_taken !== 1'b0) begin
      errors++;
      $display("FAIL nonupdating_op: flags=%b taken=%b, expected 110/0", bus16.flags, bus16.br_taken);
    end
    idle();
  endtask

  task automatic test_conditions();
    logic [2:0] states [5];
    states = '{3'b000, 3'b001, 3'b100, 3'b010, 3'b101};
    for (int s = 0; s < 5; s++) begin
      drive(1'b0, 1'b1, 4'd0, states[s][2], states[s][1], states[s][0],
            1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      checks++;
      if (bus16.flags !== states[s]) begin
        errors++;
        $display("FAIL cond_setup: flags=%b, expected %b", bus16.flags, states[s]);
      end
      for (int c = 0; c < 8; c++) begin
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'(c),
              {8'hA0, 5'(s), 3'(c)});
      end
    end
    idle();
  endtask

  task automatic test_stall();
    logic [2:0] fl0;
    int pulses;
    int br0;
    fl0    = bus16.flags;
    br0    = m16_br;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 4'd0, ~fl0[2], ~fl0[1], ~fl0[0], 1'b1, 1'b0, 1'b1, 3'b111, 16'h5A5A);
      if (bus16.br_done === 1'b1) pulses++;
    end
    checks++;
    if (bus16.flags !== fl0) begin
      errors++;
      $display("FAIL stall_flags: flags=%b, expected %b", bus16.flags, fl0);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 16'h5A5A);
    if (bus16.br_done === 1'b1) pulses++;
    // A stall right after resolution must drop br_done.
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 16'h5A5A);
    if (bus16.br_done === 1'b1) pulses++;
    checks++;
    if (pulses != 1 || bus16.br_cnt !== 16'(br0 + 1)) begin
      errors++;
      $display("FAIL stall_pulse: pulses=%0d br_cnt=%0d, expected 1/%0d",
               pulses, bus16.br_cnt, br0 + 1);
    end
    idle();
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 16'h7777);
    checks++;
    if (bus16.br_done !== 1'b0 || bus16.br_cnt !== 16'(m16_br) || bus16.taken_cnt !== 16'(m16_tk)) begin
      errors++;
      $display("FAIL flush_drop: done=%b br_cnt=%0d taken_cnt=%0d, expected 0/%0d/%0d",
               bus16.br_done, bus16.br_cnt, bus16.taken_cnt, m16_br, m16_tk);
    end
    checks++;
    if (bus16.flags !== 3'b100 || bus16.br_taken !== m_taken || bus16.br_pc !== m_pc) begin
      errors++;
      $display("FAIL flush_hold: flags=%b taken=%b pc=%h, expected 100/%b/%h",
               bus16.flags, bus16.br_taken, bus16.br_pc, m_taken, m_pc);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    int hi;
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'(i % 2), 1'b0, 1'b0, 1'b1, 3'b000,
            16'hC000 + 16'(i));
      if (bus16.br_done === 1'b1) hi++;
    end
    checks++;
    if (hi != 4) begin
      errors++;
      $display("FAIL back_to_back: br_done high %0d cycles, expected 4", hi);
    end
    idle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 16'h9000 + 16'(i));
    end
    checks++;
    if (bus4.br_cnt !== 4'd15 || bus4.taken_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_small: br_cnt=%0d taken_cnt=%0d, expected 15/15",
               bus4.br_cnt, bus4.taken_cnt);
    end
    checks++;
    if (bus16.br_cnt !== 16'(m16_br) || bus16.taken_cnt !== 16'(m16_tk)) begin
      errors++;
      $display("FAIL count_wide: br_cnt=%0d taken_cnt=%0d, expected %0d/%0d",
               bus16.br_cnt, bus16.taken_cnt, m16_br, m16_tk);
    end
    // Reset mid-burst, with a branch presented alongside it.
    drive(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 16'hDEAD);
    checks++;
    if (bus4.br_cnt !== 4'd0 || bus4.taken_cnt !== 4'd0 || bus16.br_cnt !== 16'd0 ||
        bus16.br_done !== 1'b0 || bus16.flags !== 3'b000) begin
      errors++;
      $display("FAIL sat_reset: cnt4=%0d/%0d cnt16=%0d done=%b flags=%b, expected zeros",
               bus4.br_cnt, bus4.taken_cnt, bus16.br_cnt, bus16.br_done, bus16.flags);
    end
    idle();
    checks++;
    if (bus16.br_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: br_done=%b after reset, expected 0", bus16.br_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_bypass();
    test_partial_update();
    test_conditions();
    test_stall();
    test_flush();
    test_back_to_back();
    test_saturation();
    idle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected resolutions never seen, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
